fb_port_arbiter: RTL

//   Shares the single-port 12-bit framebuffer BlockRAM between the VGA scan-out reader and the UART pixel writer.

---
 rtl/fb_port_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fb_port_arbiter.sv
// Framebuffer port arbiter: display reads first, buffered writes and
// full-frame clears use the remaining RAM cycles.
module fb_port_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 12,
  parameter int FB_WORDS   = 76800,
  parameter int FIFO_DEPTH = 8,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1,
  localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              oob_flag,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    CLEAR
  } state_t;

  localparam logic [ADDR_W-1:0] FB_END  = ADDR_W'(FB_WORDS);
  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_WORDS - 1);
  localparam logic [LVL_W-1:0]  LVL_MAX = LVL_W'(FIFO_DEPTH);

  state_t state, state_nx;

  logic [ADDR_W-1:0] f_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] f_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] clr_color;
  logic              rd_pend;

  logic push, pop, head_oob, clr_wr, clr_last;

  assign wr_ready   = (fifo_level < LVL_MAX) && (state == IDLE);
  assign push       = wr_valid && wr_ready;
  assign pop        = !rd_req && (state != CLEAR)
                      && (fifo_level != '0);
  assign head_oob   = f_addr[rptr] >= FB_END;
  assign clr_wr     = !rd_req && (state == CLEAR);
  assign clr_last   = clr_wr && (clr_cnt == FB_LAST);
  assign clear_busy = state != IDLE;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = rd_addr;
    ram_wdata = '0;
    unique case (1'b1)
      rd_req: begin
        ram_en = 1'b1;
      end
      pop: begin
        // out-of-range heads are dropped without touching the RAM
        ram_en    = !head_oob;
        ram_we    = !head_oob;
        ram_addr  = f_addr[rptr];
        ram_wdata = f_data[rptr];
      end
      clr_wr: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = clr_cnt;
        ram_wdata = clr_color;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (clear_start) state_nx = DRAIN;
      DRAIN: if (fifo_level == '0) state_nx = CLEAR;
      CLEAR: if (clr_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      f_addr[wptr] <= wr_addr;
      f_data[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      clr_cnt    <= '0;
      clr_color  <= '0;
      oob_flag   <= 1'b0;
      clear_done <= 1'b0;
      rd_pend    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      state      <= state_nx;
      clear_done <= clr_last;
      rd_pend    <= rd_req;
      rd_valid   <= rd_pend;
      if (rd_pend) rd_data <= ram_rdata;
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop) rptr <= rptr + PTR_W'(1);
      if (push && !pop) fifo_level <= fifo_level + LVL_W'(1);
      else if (pop && !push) fifo_level <= fifo_level - LVL_W'(1);
      if (pop && head_oob) oob_flag <= 1'b1;
      if (state == IDLE && clear_start) clr_color <= clear_color;
      if (clr_last) clr_cnt <= '0;
      else if (clr_wr) clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end

endmodule
